// File: rtl/reg_readback_pkg.sv
// -----------------------------------------------------------------------------
// reg_readback_pkg
// Shared definitions for the register readback controller.
//   rbState_e  : controller state (IDLE, LATCH, SHIFT, DONE)
//   SHIFT_LEN  : bits per attached read-only register
//   CNT_W      : width of the shift bit counter (wraps 31 -> 0)
//   evenParity : XOR reduction of a captured word
// -----------------------------------------------------------------------------
package reg_readback_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } rbState_e;

    localparam int unsigned SHIFT_LEN = 32;
    localparam int unsigned CNT_W     = 5;

    function automatic logic evenParity(input logic [SHIFT_LEN-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/reg_readback_ctrl.sv
// -----------------------------------------------------------------------------
// reg_readback_ctrl
// Serial readback controller for NREG external 32-bit read-only registers.
// A request latches the selected register (latchOut one-hot strobe), shifts
// its contents in MSB first over 32 enabled cycles (shiftEn one-hot), then
// presents the word for one enabled cycle on rdValid. Out-of-range addresses
// complete immediately with rdErr=1 and rdData=0.
//
// Ports
//   bclk       in   clock, all state on posedge
//   rstb       in   synchronous active-low reset (overrides clkEn)
//   clkEn      in   clock enable, 0 freezes all state and outputs
//   rdReq      in   readback request, accepted only while rdReady=1
//   rdAddr     in   [ADDRW] register index
//   rdReady    out  high in IDLE only
//   latchOut   out  [NREG] one-hot parallel-load strobe
//   shiftEn    out  [NREG] one-hot shift enable
//   shiftIn    in   [NREG] serial bit per register (0 when not enabled)
//   rdValid    out  result pulse (one enabled cycle)
//   rdData     out  [32] captured word, held until next result
//   rdErr      out  result was for an address >= NREG
//   rdAddrOut  out  [ADDRW] address echoed with the result
//   rdParity   out  XOR of rdData (only with READBACK_PARITY_EN defined)
//
// Configuration macro: READBACK_PARITY_EN adds the rdParity output.
// -----------------------------------------------------------------------------
module reg_readback_ctrl
    import reg_readback_pkg::*;
#(
    parameter int unsigned NREG  = 8,
    parameter int unsigned ADDRW = 3
) (
    input  logic                 bclk,
    input  logic                 rstb,
    input  logic                 clkEn,
    input  logic                 rdReq,
    input  logic [ADDRW-1:0]     rdAddr,
    output logic                 rdReady,
    output logic [NREG-1:0]      latchOut,
    output logic [NREG-1:0]      shiftEn,
    input  logic [NREG-1:0]      shiftIn,
    output logic                 rdValid,
    output logic [SHIFT_LEN-1:0] rdData,
    output logic                 rdErr,
    output logic [ADDRW-1:0]     rdAddrOut
`ifdef READBACK_PARITY_EN
    ,
    output logic                 rdParity
`endif
);

    rbState_e             state;
    logic [ADDRW-1:0]     addrReg;
    logic [CNT_W-1:0]     bitCnt;
    logic [SHIFT_LEN-1:0] capture;

    logic                 addrInRange;
    logic [NREG-1:0]      reqOneHot;
    logic [NREG-1:0]      regOneHot;
    logic                 selBit;
    logic [SHIFT_LEN-1:0] captureNext;

    always_comb begin
        addrInRange = (32'(rdAddr) < NREG);
        reqOneHot   = NREG'(1) << rdAddr;
        regOneHot   = NREG'(1) << addrReg;
        // Unselected registers drive 0 and shiftEn is one-hot, so masking
        // and OR-reducing picks the selected bit without an address mux.
        selBit      = |(shiftIn & shiftEn);
        captureNext = {capture[SHIFT_LEN-2:0], selBit};
    end

    always_ff @(posedge bclk) begin
        if (!rstb) begin
            state     <= IDLE;
            rdReady   <= 1'b1;
            latchOut  <= '0;
            shiftEn   <= '0;
            rdValid   <= 1'b0;
            rdErr     <= 1'b0;
            rdData    <= '0;
            rdAddrOut <= '0;
            bitCnt    <= '0;
            addrReg   <= '0;
            capture   <= '0;
`ifdef READBACK_PARITY_EN
            rdParity  <= 1'b0;
`endif
        end else if (clkEn) begin
            unique case (state)
                IDLE: begin
                    // rdReady is 1 throughout IDLE, so rdReq alone accepts.
                    if (rdReq) begin
                        addrReg <= rdAddr;
                        rdReady <= 1'b0;
                        if (addrInRange) begin
                            latchOut <= reqOneHot;
                            state    <= LATCH;
                        end else begin
                            rdValid   <= 1'b1;
                            rdErr     <= 1'b1;
                            rdData    <= '0;
                            rdAddrOut <= rdAddr;
`ifdef READBACK_PARITY_EN
                            rdParity  <= 1'b0;
`endif
                            state     <= DONE;
                        end
                    end
                end

                LATCH: begin
                    latchOut <= '0;
                    shiftEn  <= regOneHot;
                    bitCnt   <= '0;
                    capture  <= '0;
                    state    <= SHIFT;
                end

                SHIFT: begin
                    capture <= captureNext;
                    bitCnt  <= bitCnt + 1'b1;
                    // Final bit: load the result straight from the shifted
                    // word so DONE presents it without an extra cycle.
                    if (bitCnt == CNT_W'(SHIFT_LEN - 1)) begin
                        shiftEn   <= '0;
                        rdValid   <= 1'b1;
                        rdErr     <= 1'b0;
                        rdData    <= captureNext;
                        rdAddrOut <= addrReg;
`ifdef READBACK_PARITY_EN
                        rdParity  <= evenParity(captureNext);
`endif
                        state     <= DONE;
                    end
                end

                DONE: begin
                    rdValid <= 1'b0;
                    rdReady <= 1'b1;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/reg_readback_ctrl.md
REG_READBACK_CTRL -- requirements
Module: reg_readback_ctrl

Interface
REQ-001 Parameter NREG, 8: number of attached 32-bit read-only registers (1..32).
REQ-002 Parameter ADDRW, 3: width of rdAddr; SHALL satisfy 2**ADDRW >= NREG.
REQ-003 bclk  input  1  clock; all state updates on posedge bclk.
REQ-004 rstb  input  1  reset, synchronous, active-low.
REQ-005 clkEn  input  1  clock enable; when 0, all state and outputs hold.
REQ-006 rdReq  input  1  readback request.
REQ-007 rdAddr  input  ADDRW  index of register to read.
REQ-008 rdReady  output  1  request accept; high only in IDLE.
REQ-009 latchOut  output  NREG  one-hot parallel-load strobe to selected register.
REQ-010 shiftEn  output  NREG  one-hot shift enable to selected register.
REQ-011 shiftIn  input  NREG  serial bit from each register, MSB first; a register outputs 0 when its shiftEn is low.
REQ-012 rdValid  output  1  one-cycle pulse; readback result available.
REQ-013 rdData  output  32  captured register value.
REQ-014 rdErr  output  1  qualifies rdValid: rdAddr was >= NREG.
REQ-015 rdAddrOut  output  ADDRW  address echoed with the result.

Function
REQ-016 Accept occurs on an enabled edge with rdReq=1 and rdReady=1; rdAddr is registered at accept.
REQ-017 FSM states: IDLE, LATCH, SHIFT, DONE; transitions only on clkEn=1 edges.
REQ-018 IDLE->LATCH on accept with a valid address; IDLE->DONE on accept with address >= NREG.
REQ-019 LATCH lasts exactly 1 enabled cycle with latchOut[addr]=1 and all shiftEn=0; next state SHIFT.
REQ-020 SHIFT lasts exactly 32 enabled cycles with shiftEn[addr]=1 and latchOut=0; each cycle the capture register shifts left, inserting shiftIn[addr] at bit 0.
REQ-021 Bit-counter wrap (31->0) moves SHIFT->DONE; the first captured bit becomes rdData[31].
REQ-022 DONE lasts 1 enabled cycle: rdValid=1, rdData=capture (0 if error), rdErr set per REQ-014, rdAddrOut=accepted address; next state IDLE.
REQ-023 Accept-to-rdValid latency is 34 enabled cycles for a valid address and 1 enabled cycle for an invalid one.
REQ-024 rdData, rdErr and rdAddrOut hold their values until the next DONE.
REQ-025 rdReq is ignored outside IDLE; no queuing.
REQ-026 At most one bit of latchOut|shiftEn is ever high.
REQ-027 With clkEn=0 mid-operation, the FSM, counter and outputs freeze; the operation resumes unchanged on clkEn=1.

Reset
REQ-028 rstb=0 at a bclk edge, regardless of clkEn, SHALL force: IDLE, latchOut=0, shiftEn=0, rdValid=0, rdErr=0, rdData=0, rdAddrOut=0, counter=0.
REQ-029 Reset mid-LATCH or mid-SHIFT aborts the operation with no rdValid; rdReady=1 on the first post-reset cycle.

Configuration
REQ-030 Macro READBACK_PARITY_EN: when defined, adds output rdParity (1 bit) = even parity (XOR) of the 32 captured bits, updated in DONE, 0 on error and on reset; when undefined, the port and its logic are absent.

Structure
REQ-031 Shared package reg_readback_pkg holds the state enum (IDLE, LATCH, SHIFT, DONE), the SHIFT_LEN=32 constant and the 5-bit counter width.
REQ-032 No sub-module; the attached reg32ro instances remain external, one per shiftIn/latchOut/shiftEn index.

Verification
REQ-033 8 reg32ro models, reg 5 = 0xA5C3_0F81; request addr 5 -> latchOut[5] for 1 cycle, shiftEn[5] for 32 cycles, rdValid 34 cycles after accept, rdData=0xA5C3_0F81, rdErr=0.
REQ-034 Request addr 7 while reg 7 = 0xFFFF_FFFF, then addr 0 = 0x0000_0001 issued back-to-back -> second accept only after rdReady returns; results 0xFFFFFFFF then 0x00000001; rdReq held during busy is ignored.
REQ-035 NREG=6, request addr 6 -> no latchOut/shiftEn activity; rdValid 1 cycle after accept with rdErr=1, rdData=0.
REQ-036 Toggle clkEn 0/1 every other cycle during SHIFT of 0x1234_5678 -> rdData=0x12345678 after 68 bclk cycles; the one-hot check holds throughout.
REQ-037 Assert rstb=0 at SHIFT bit 10 -> all strobes 0 on the next cycle, no rdValid, rdReady=1; a fresh read then returns the correct value.
REQ-038 With READBACK_PARITY_EN, read 0x0000_0007 -> rdParity=1; read 0x0000_0003 -> rdParity=0.
